// File: rtl/cloud_scroller.sv
// cloud_scroller: cloud position/height state and per-pixel cloud output.
// Scrolls left on frame ticks, respawns at an LFSR-chosen height.
module cloud_scroller #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int CLOUD_W   = 70,
  parameter int CLOUD_H   = 39,
  parameter int SPEED_DIV = 2,
  parameter int INIT_X    = 500,
  parameter int INIT_Y    = 60,
  parameter int Y_MIN     = 40,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [10:0]        hc,
  input  logic [10:0]        vc,
  input  logic               game_run,
  input  logic [CLOUD_W-1:0] row_in,
  output logic [10:0]        cloud_y,
  output logic [10:0]        cloud_x,
  output logic               cloud_px
);

  localparam int DW = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;

  localparam logic [11:0] W12  = 12'(CLOUD_W);
  localparam logic [11:0] H12  = 12'(CLOUD_H);
  localparam logic [11:0] HA12 = 12'(H_ACTIVE);
  localparam logic [11:0] VA12 = 12'(V_ACTIVE);

  localparam logic [10:0] X_INIT = 11'(INIT_X);
  localparam logic [10:0] Y_INIT = 11'(INIT_Y);
  localparam logic [10:0] X_RESP = 11'(H_ACTIVE + CLOUD_W);
  localparam logic [10:0] Y_BASE = 11'(Y_MIN);
  localparam logic [10:0] V_TICK = 11'(V_ACTIVE);
  localparam logic [DW-1:0] DIV_LAST = DW'(SPEED_DIV - 1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RUN     = 2'd1,
    RESPAWN = 2'd2
  } state_t;

  state_t          state_q;
  logic [10:0]     x_q;
  logic [10:0]     y_q;
  logic [DW-1:0]   div_q;
  logic [7:0]      lfsr_q;
  logic [7:0]      lfsr_d;
  logic            px_q;
  logic            px_d;

  logic            frame_tick;
  logic            div_due;

  logic [11:0]     hc12;
  logic [11:0]     vc12;
  logic [11:0]     x12;
  logic [11:0]     y12;
  logic            in_x;
  logic            in_y;
  logic            on_scr;
  logic [11:0]     col;
  logic [11:0]     bit_idx;
  logic            row_bit;

  // First pixel of vertical blanking marks the frame boundary.
  assign frame_tick = (vc == V_TICK) && (hc == 11'd0);
  assign div_due    = (div_q == DIV_LAST);

  // Fibonacci LFSR, taps 8,6,5,4; never leaves the non-zero cycle.
  assign lfsr_d = {lfsr_q[6:0],
                   lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // Scroll FSM with registered position, height, divider and LFSR.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HOLD;
      x_q     <= X_INIT;
      y_q     <= Y_INIT;
      div_q   <= '0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      if (frame_tick) begin
        lfsr_q <= lfsr_d;
      end
      unique case (state_q)
        HOLD: begin
          if (frame_tick && game_run) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (frame_tick) begin
            if (!game_run) begin
              state_q <= HOLD;
            end else if (div_due) begin
              div_q <= '0;
              if (x_q == 11'd0) begin
                state_q <= RESPAWN;
              end else begin
                x_q <= x_q - 11'd1;
              end
            end else begin
              div_q <= div_q + DW'(1);
            end
          end
        end
        RESPAWN: begin
          x_q     <= X_RESP;
          y_q     <= Y_BASE + {4'd0, lfsr_q[6:0]};
          state_q <= RUN;
        end
        default: begin
          state_q <= HOLD;
        end
      endcase
    end
  end

  assign hc12 = {1'b0, hc};
  assign vc12 = {1'b0, vc};
  assign x12  = {1'b0, x_q};
  assign y12  = {1'b0, y_q};

  assign in_x    = (hc12 < x12) && ((hc12 + W12) >= x12);
  assign in_y    = (vc12 >= y12) && (vc12 < (y12 + H12));
  assign on_scr  = (hc12 < HA12) && (vc12 < VA12);
  assign col     = hc12 + W12 - x12;
  assign bit_idx = (W12 - 12'd1) - col;

  // Bit select from the ROM row; bit CLOUD_W-1 is the leftmost pixel.
  always_comb begin
    row_bit = 1'b0;
    for (int i = 0; i < CLOUD_W; i++) begin
      if (bit_idx == 12'(i)) begin
        row_bit = row_in[i];
      end
    end
  end

  assign px_d = in_x && in_y && on_scr && row_bit;

  // Pixel output register, one clock behind hc/vc.
  always_ff @(posedge clk) begin
    if (reset) begin
      px_q <= 1'b0;
    end else begin
      px_q <= px_d;
    end
  end

  assign cloud_x  = x_q;
  assign cloud_y  = y_q;
  assign cloud_px = px_q;

endmodule
